bram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for port A of the dual-port 48-bit x 1024-word block RAM.
- Each requester presents a single read or write through a req/gnt handshake.
- The block owns the RAM port A address, data and write-enable lines, and returns read data with a one-cycle rvalid pulse.
- Port B is not driven by this block. It stays with the existing BRAM test sequencer or is tied off at the top level.

---
 rtl/bram_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Two-requester round-robin arbiter and sequencer for port A of
//               a 48-bit x 1024-word dual-port block RAM. Each requester issues
//               one read or write per req/gnt handshake. The block drives the
//               RAM port A address/data/write-enable and returns read data to
//               the owning requester with a one-cycle rvalid pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk                      system clock, rising-edge
//   reset                    asynchronous active-high reset
//   req0/we0/addr0/wdata0    requester 0 request, op, address, write data
//   gnt0/rvalid0/rdata0      requester 0 grant pulse, read-valid pulse, data
//   req1/we1/addr1/wdata1    requester 1 request, op, address, write data
//   gnt1/rvalid1/rdata1      requester 1 grant pulse, read-valid pulse, data
//   addr_a/data_a/we_a       RAM port A address, write data, write enable
//   q_a                      RAM port A read data (one cycle after address)
//   busy                     high whenever a transaction is in flight
// ============================================================================
module bram_port_arbiter #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  // requester 1
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  // RAM port A
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  output logic              we_a,
  input  logic [DATA_W-1:0] q_a,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              state_q;
  logic                last_grant_q;  // requester granted most recently
  logic                owner_q;       // requester owning the in-flight access
  logic                op_we_q;       // in-flight access is a write

  logic                gnt0_q;
  logic                gnt1_q;
  logic                rvalid0_q;
  logic                rvalid1_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic [ADDR_W-1:0]   addr_a_q;
  logic [DATA_W-1:0]   data_a_q;
  logic                we_a_q;
  logic                busy_q;

  // Arbitration result, only consumed while idle.
  logic                arb_valid_d;
  logic                arb_winner_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not granted last time wins, so held requests strictly alternate.
  always_comb begin
    arb_valid_d  = req0 | req1;
    arb_winner_d = 1'b0;
    if (req0 && req1) begin
      arb_winner_d = ~last_grant_q;
    end else if (req1) begin
      arb_winner_d = 1'b1;
    end
  end

  always_comb begin
    if (arb_winner_d) begin
      sel_we_d    = we1;
      sel_addr_d  = addr1;
      sel_wdata_d = wdata1;
    end else begin
      sel_we_d    = we0;
      sel_addr_d  = addr0;
      sel_wdata_d = wdata0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;   // requester 0 wins the first tie
      owner_q      <= 1'b0;
      op_we_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      addr_a_q     <= '0;
      data_a_q     <= '0;
      we_a_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Grant and read-valid are single-cycle pulses.
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (arb_valid_d) begin
            addr_a_q     <= sel_addr_d;
            data_a_q     <= sel_wdata_d;
            we_a_q       <= sel_we_d;
            gnt0_q       <= ~arb_winner_d;
            gnt1_q       <= arb_winner_d;
            last_grant_q <= arb_winner_d;
            owner_q      <= arb_winner_d;
            op_we_q      <= sel_we_d;
            busy_q       <= 1'b1;
            state_q      <= S_ACCESS;
          end else begin
            // Address and data deliberately hold; only the strobe drops.
            we_a_q <= 1'b0;
          end
        end

        S_ACCESS: begin
          // The RAM samples port A at this edge; the write strobe is one
          // cycle wide.
          we_a_q <= 1'b0;
          if (op_we_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          // q_a now reflects the address sampled at the previous edge.
          if (owner_q) begin
            rdata1_q  <= q_a;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= q_a;
            rvalid0_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          we_a_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign addr_a  = addr_a_q;
  assign data_a  = data_a_q;
  assign we_a    = we_a_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Self-checking bench for bram_port_arbiter. A transaction-level
//               model predicts every output each cycle; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

  localparam int DW = 48;
  localparam int AW = 10;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a;
  logic          we_a;
  logic [DW-1:0] q_a;
  logic          busy;

  int n_pass = 0;
  int n_tot  = 0;
  logic chk_en = 1'b0;

  bram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .we0    (we0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .gnt0   (gnt0),
    .rvalid0(rvalid0),
    .rdata0 (rdata0),
    .req1   (req1),
    .we1    (we1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .gnt1   (gnt1),
    .rvalid1(rvalid1),
    .rdata1 (rdata1),
    .addr_a (addr_a),
    .data_a (data_a),
    .we_a   (we_a),
    .q_a    (q_a),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port view of the block RAM (read-first).
  logic [DW-1:0] ram [0:1023];
  logic          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
      ram_init <= 1'b1;
      q_a      <= '0;
    end else begin
      if (we_a) ram[addr_a] <= data_a;
      q_a <= ram[addr_a];
    end
  end

  // --------------------------------------------------------------------------
  // Transaction-level model: a grant starts a transaction lasting 1 cycle
  // (write) or 2 cycles (read); a read completes by returning the memory
  // contents to its owner.
  // --------------------------------------------------------------------------
  int            m_rem;
  logic          m_last, m_own, m_op_we, m_w, m_init = 1'b0;
  logic [1:0]    m_gnt, m_rv;
  logic [DW-1:0] m_rdata [2];
  logic          m_we_a;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] mem_model [0:1023];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      if (!m_init) begin
        for (int i = 0; i < 1024; i++) mem_model[i] = '0;
        m_init = 1'b1;
      end
      m_rem = 0; m_last = 1'b1; m_own = 1'b0; m_op_we = 1'b0;
      m_gnt = 2'b00; m_rv = 2'b00; m_we_a = 1'b0;
      m_addr = '0; m_data = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else begin
      m_gnt = 2'b00; m_rv = 2'b00; m_we_a = 1'b0;
      if (m_rem != 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0 && !m_op_we) begin
          m_rv[m_own]    = 1'b1;
          m_rdata[m_own] = mem_model[m_addr];
        end
      end else if (req0 || req1) begin
        m_w = (req0 && req1) ? ~m_last : req1;
        m_gnt[m_w] = 1'b1;
        m_last  = m_w;
        m_own   = m_w;
        m_op_we = m_w ? we1 : we0;
        m_addr  = m_w ? addr1 : addr0;
        m_data  = m_w ? wdata1 : wdata0;
        m_we_a  = m_op_we;
        m_rem   = m_op_we ? 1 : 2;
        if (m_op_we) mem_model[m_addr] = m_data;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("cyc_ctl", {58'b0, gnt0, gnt1, rvalid0, rvalid1, busy, we_a},
                     {58'b0, m_gnt[0], m_gnt[1], m_rv[0], m_rv[1], (m_rem != 0), m_we_a});
      chk("cyc_addr_a", {54'b0, addr_a}, {54'b0, m_addr});
      chk("cyc_data_a", {16'b0, data_a}, {16'b0, m_data});
      chk("cyc_rdata0", {16'b0, rdata0}, {16'b0, m_rdata[0]});
      chk("cyc_rdata1", {16'b0, rdata1}, {16'b0, m_rdata[1]});
    end
  end

  // Present a request, wait (bounded) for its grant, then drop it.
  task automatic issue(input logic r, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    int k;
    @(negedge clk);
    if (r) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    k = 0;
    do begin @(negedge clk); k++; end while (!(r ? gnt1 : gnt0) && k < 20);
    chk("issue_gnt", {63'b0, (r ? gnt1 : gnt0)}, 64'd1);
    if (r) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20) begin @(negedge clk); k++; end
    chk("wait_idle", {63'b0, busy}, 64'd0);
  endtask

  task automatic wait_rv(input logic r);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(r ? rvalid1 : rvalid0) && k < 10);
    chk("wait_rvalid", {63'b0, (r ? rvalid1 : rvalid0)}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    int seq [4];
    int ng, nrv, rv0c, rv1c, k, g0c;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", {58'b0, gnt0, gnt1, rvalid0, rvalid1, busy, we_a}, 64'd0);
    chk("rst_addr_a", {54'b0, addr_a}, 64'd0);
    chk("rst_rdata0", {16'b0, rdata0}, 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // T1: write 0x005
    issue(1'b0, 1'b1, 10'h005, 48'h123456789ABC);
    chk("t1_gnt0", {62'b0, gnt0, gnt1}, 64'b10);
    chk("t1_we_a", {63'b0, we_a}, 64'd1);
    chk("t1_addr_a", {54'b0, addr_a}, 64'h005);
    chk("t1_data_a", {16'b0, data_a}, 64'h123456789ABC);
    chk("t1_busy", {63'b0, busy}, 64'd1);
    @(negedge clk);
    chk("t1_after", {60'b0, gnt0, we_a, rvalid0, busy}, 64'd0);
    wait_idle();

    // T2: read 0x005 back
    issue(1'b0, 1'b0, 10'h005, '0);
    @(negedge clk);
    chk("t2_rv_early", {63'b0, rvalid0}, 64'd0);
    @(negedge clk);
    chk("t2_rvalid0", {62'b0, rvalid0, rvalid1}, 64'b10);
    chk("t2_rdata0", {16'b0, rdata0}, 64'h123456789ABC);
    chk("t2_rdata1", {16'b0, rdata1}, 64'd0);
    wait_idle();

    // Preload 0x001 and 0x002 (leaves requester 1 as last grant)
    issue(1'b0, 1'b1, 10'h001, 48'hAAAA00000001); wait_idle();
    issue(1'b1, 1'b1, 10'h002, 48'h555500000002); wait_idle();

    // T4: top address via requester 1
    issue(1'b1, 1'b1, 10'h3FF, 48'hFFFFFFFFFFFF); wait_idle();
    issue(1'b1, 1'b0, 10'h3FF, '0); wait_rv(1'b1);
    chk("t4_rdata1_top", {16'b0, rdata1}, 64'hFFFFFFFFFFFF);
    wait_idle();
    issue(1'b1, 1'b0, 10'h000, '0); wait_rv(1'b1);
    chk("t4_rdata1_zero", {16'b0, rdata1}, 64'd0);
    chk("t4_rdata0_kept", {16'b0, rdata0}, 64'h123456789ABC);
    wait_idle();

    // T3: both requesters hold reads; grants must alternate starting at 0
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 10'h001;
    req1 = 1; we1 = 0; addr1 = 10'h002;
    ng = 0; nrv = 0; rv0c = 0; rv1c = 0; k = 0;
    while (nrv < 4 && k < 60) begin
      @(negedge clk); k++;
      chk("t3_overlap", {62'b0, gnt0 & gnt1, rvalid0 & rvalid1}, 64'd0);
      if ((gnt0 || gnt1) && ng < 4) begin seq[ng] = gnt1 ? 1 : 0; ng++; end
      if (ng == 4) begin req0 = 0; req1 = 0; end
      if (rvalid0) begin rv0c++; nrv++; chk("t3_rdata0", {16'b0, rdata0}, 64'hAAAA00000001); end
      if (rvalid1) begin rv1c++; nrv++; chk("t3_rdata1", {16'b0, rdata1}, 64'h555500000002); end
    end
    chk("t3_done", 64'(nrv), 64'd4);
    chk("t3_order", {60'b0, seq[0][0], seq[1][0], seq[2][0], seq[3][0]}, 64'b0101);
    chk("t3_rv_split", {32'(rv0c), 32'(rv1c)}, {32'd2, 32'd2});
    wait_idle();

    // T5: reset while the read sits in CAPTURE
    issue(1'b0, 1'b0, 10'h001, '0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_ctl", {58'b0, gnt0, gnt1, rvalid0, rvalid1, busy, we_a}, 64'd0);
    chk("t5_rst_data", {16'b0, rdata0 | rdata1 | data_a}, 64'd0);
    chk("t5_rst_addr", {54'b0, addr_a}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_rvalid", {62'b0, rvalid0, rvalid1}, 64'd0);
    end
    req0 = 1; we0 = 0; addr0 = 10'h002;
    req1 = 1; we1 = 0; addr1 = 10'h001;
    k = 0;
    do begin @(negedge clk); k++; end while (!(gnt0 || gnt1) && k < 20);
    chk("t5_tie_gnt0", {62'b0, gnt0, gnt1}, 64'b10);
    req0 = 0; req1 = 0;
    wait_idle();

    // T6: short req0 pulse while busy must be ignored
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 10'h002;
    k = 0;
    do begin @(negedge clk); k++; end while (!gnt1 && k < 20);
    chk("t6_gnt1", {63'b0, gnt1}, 64'd1);
    req1 = 0;
    req0 = 1; we0 = 0; addr0 = 10'h001;
    @(negedge clk);
    req0 = 0;
    g0c = 0;
    repeat (6) begin
      @(negedge clk);
      if (gnt0) g0c++;
    end
    chk("t6_no_gnt0", 64'(g0c), 64'd0);
    chk("t6_busy_low", {63'b0, busy}, 64'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
